// File: rtl/axi_id_killer_rd.sv
// AXI4 read-channel ID restorer: strips ARID toward a single-ID port and re-attaches it to R beats in order.
// Zero-latency combinational AR/R paths; backpressure passes straight through, gated by the ID queue's full/empty.
module axi_id_killer_rd #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic                  m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic [CW-1:0]         outstanding,
  output logic                  err
);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [ID_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]       r_rp;
  logic [PW-1:0]       r_wp;
  logic                r_full;
  logic                r_empty;
  logic [CW-1:0]       r_count;
  logic                r_err;

  logic          w_push;
  logic          w_rfire;
  logic          w_pop;
  logic [PW-1:0] w_rp_next;
  logic [PW-1:0] w_wp_next;

  assign w_push    = s_arvalid & m_arready & ~r_full;
  assign w_rfire   = m_rvalid & s_rready & ~r_empty;
  assign w_pop     = w_rfire & m_rlast;
  assign w_rp_next = (r_rp == LAST_IDX) ? '0 : r_rp + PW'(1);
  assign w_wp_next = (r_wp == LAST_IDX) ? '0 : r_wp + PW'(1);

  assign m_arvalid = s_arvalid & ~r_full;
  assign s_arready = m_arready & ~r_full;
  assign m_arid    = 1'b0;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;

  assign s_rvalid  = m_rvalid & ~r_empty;
  assign m_rready  = s_rready & ~r_empty;
  assign s_rid     = r_data[r_rp];
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;

  assign outstanding = r_count;
  assign err         = r_err;

  // ID storage needs no reset: entries are only read while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wp] <= s_arid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= w_wp_next;
      end
      if (w_pop) begin
        r_rp <= w_rp_next;
      end

      if (w_push) begin
        r_empty <= 1'b0;
      end else if (w_pop && (w_rp_next == r_wp)) begin
        r_empty <= 1'b1;
      end

      if (w_pop) begin
        r_full <= 1'b0;
      end else if (w_push && (w_wp_next == r_rp)) begin
        r_full <= 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // A response with nothing outstanding is held off, never dropped.
      if (m_rvalid && r_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_id_killer_rd.sv
// Bench for axi_id_killer_rd: queue-based reference model checked every cycle, plus directed literal checks.
module tb_axi_id_killer_rd;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 8;
  localparam int CW         = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rst;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;
  logic [1:0]            s_arburst;
  logic                  m_arvalid;
  logic                  m_arready;
  logic                  m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [ID_WIDTH-1:0]   s_rid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic [CW-1:0]         outstanding;
  logic                  err;

  axi_id_killer_rd #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .outstanding(outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of outstanding IDs plus a sticky error bit.
  int mq[$];
  bit m_err;
  bit model_on = 0;
  bit e_full;
  bit e_empty;
  bit mp_push;
  bit mp_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_err    = 0;
      model_on = 1;
    end else if (model_on) begin
      mp_push = s_arvalid && m_arready && (mq.size() < DEPTH);
      mp_pop  = m_rvalid && s_rready && m_rlast && (mq.size() > 0);
      if (m_rvalid && mq.size() == 0) m_err = 1;
      if (mp_pop) void'(mq.pop_front());
      if (mp_push) mq.push_back(int'(s_arid));
    end
  end

  int got[$];

  always @(negedge clk) begin
    if (model_on) begin
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      check("m_arvalid", m_arvalid, s_arvalid & ~e_full);
      check("s_arready", s_arready, m_arready & ~e_full);
      check("m_arid", m_arid, 0);
      check("m_araddr", m_araddr, s_araddr);
      check("m_arlen", m_arlen, s_arlen);
      check("m_arsize", m_arsize, s_arsize);
      check("m_arburst", m_arburst, s_arburst);
      check("s_rvalid", s_rvalid, m_rvalid & ~e_empty);
      check("m_rready", m_rready, s_rready & ~e_empty);
      check("s_rdata", s_rdata, m_rdata);
      check("s_rresp", s_rresp, m_rresp);
      check("s_rlast", s_rlast, m_rlast);
      check("outstanding", outstanding, mq.size());
      check("err", err, m_err);
      if (m_rvalid && !e_empty) check("s_rid", s_rid, mq[0]);
      if (s_rvalid && s_rready) got.push_back(int'(s_rid));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check(name, got[i], exp[i]);
    end
  endtask

  int exp_q[$];

  initial begin
    rst = 1; s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0;
    s_arburst = 0; m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    s_rready = 0;
    cyc(); cyc();
    rst = 0; m_arready = 1;
    #1;
    check("idle_outstanding", outstanding, 0);
    check("idle_s_arready", s_arready, 1);
    check("idle_m_arid", m_arid, 0);
    check("idle_s_rvalid", s_rvalid, 0);
    check("idle_err", err, 0);

    // Single 4-beat burst with ID 5
    cyc();
    s_arvalid = 1; s_arid = 4'h5; s_arlen = 8'd3; s_arsize = 3'd2; s_arburst = 2'd1;
    s_araddr = 32'h0000_1000;
    cyc();
    s_arvalid = 0;
    #1 check("burst_outstanding_1", outstanding, 1);
    got.delete();
    s_rready = 1; m_rvalid = 1;
    for (int b = 0; b < 4; b++) begin
      m_rdata = $urandom; m_rresp = 2'(b); m_rlast = (b == 3);
      cyc();
    end
    m_rvalid = 0; m_rlast = 0;
    #1 check("burst_outstanding_0", outstanding, 0);
    exp_q = '{5, 5, 5, 5};
    check_seq("burst_rid", exp_q);

    // Fill to DEPTH, then a 9th attempt coinciding with a pop must be refused
    got.delete();
    s_rready = 0; s_arlen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      s_arvalid = 1; s_arid = 4'(i); s_araddr = $urandom;
      cyc();
    end
    s_arid = 4'h8; m_rvalid = 1; m_rlast = 1; s_rready = 1;
    #1;
    check("full_s_arready", s_arready, 0);
    check("full_m_arvalid", m_arvalid, 0);
    check("full_outstanding", outstanding, 8);
    cyc();
    s_arvalid = 0;
    #1 check("full_pop_outstanding", outstanding, 7);
    repeat (7) cyc();
    m_rvalid = 0; m_rlast = 0;
    #1 check("fill_drained", outstanding, 0);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("fill_rid", exp_q);

    // Concurrent push/pop across pointer wrap
    got.delete();
    s_rready = 1; s_arvalid = 1; s_arid = 4'hA;
    cyc();
    for (int i = 0; i < 20; i++) begin
      s_arid = 4'((11 + i) % 16); s_araddr = $urandom;
      m_rvalid = 1; m_rlast = 1; m_rdata = $urandom;
      #1 check("wrap_outstanding", outstanding, 1);
      cyc();
    end
    s_arvalid = 0;
    cyc();
    m_rvalid = 0; m_rlast = 0;
    #1 check("wrap_drained", outstanding, 0);
    exp_q.delete();
    for (int k = 0; k < 21; k++) exp_q.push_back((10 + k) % 16);
    check_seq("wrap_rid", exp_q);

    // Backpressure with two bursts queued: ID must stay on the head
    got.delete();
    s_rready = 0; s_arvalid = 1; s_arid = 4'h3; s_arlen = 8'd1;
    cyc();
    s_arid = 4'h9; s_arlen = 8'd0;
    cyc();
    s_arvalid = 0; m_rvalid = 1; m_rlast = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_m_rready", m_rready, 0);
      check("bp_s_rid", s_rid, 4'h3);
      cyc();
    end
    s_rready = 1;
    cyc();
    m_rlast = 1;
    cyc();
    #1 check("bp_outstanding", outstanding, 1);
    cyc();
    m_rvalid = 0; m_rlast = 0;
    exp_q = '{3, 3, 9};
    check_seq("bp_rid", exp_q);

    // Spurious response with empty queue
    #1 check("pre_spurious_err", err, 0);
    m_rvalid = 1; m_rlast = 1;
    #1;
    check("spur_s_rvalid", s_rvalid, 0);
    check("spur_m_rready", m_rready, 0);
    cyc();
    m_rvalid = 0; m_rlast = 0;
    #1 check("spur_err_set", err, 1);
    cyc();
    #1 check("spur_err_sticky", err, 1);
    s_arvalid = 1; s_arid = 4'h4;
    cyc();
    s_arvalid = 0;
    #1 check("pre_rst_outstanding", outstanding, 1);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    check("rst_err", err, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_s_arready", s_arready, 1);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
